// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the memory bus arbiter slice.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } requester_t;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 255;
  localparam int unsigned ARB_CNT_WIDTH       = 16;

endpackage

// File: rtl/mem_bus_rr_pick.sv
// Two-way round-robin picker: on a tie, the requester that did not win last time is chosen.
module mem_bus_rr_pick
  import cpu_bus_pkg::*;
(
  input  logic [1:0] req,
  input  requester_t last_grant,
  output requester_t winner,
  output logic       any_req
);

  // req[0] is the icache, req[1] the dcache
  always_comb begin
    winner  = ICACHE;
    any_req = |req;
    case (req)
      2'b01:   winner = ICACHE;
      2'b10:   winner = DCACHE;
      2'b11:   winner = (last_grant == ICACHE) ? DCACHE : ICACHE;
      default: winner = ICACHE;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between icache and dcache, one transaction at a time,
// with a watchdog that turns a hung transaction into an error response.
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned LINE_WIDTH     = 128,
  parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_available,
  output logic                  i_resp_valid,
  output logic                  i_resp_error,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_available,
  output logic                  d_resp_valid,
  output logic                  d_resp_error,
  output logic [LINE_WIDTH-1:0] resp_data,
  output logic                  mem_req_valid,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [LINE_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [LINE_WIDTH-1:0] mem_resp_data,
  output logic                  bus_error
);

  localparam logic [ARB_CNT_WIDTH-1:0] CNT_LAST = ARB_CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [ARB_CNT_WIDTH-1:0] CNT_MAX  = '1;

  arb_state_t             state_q, state_d;
  requester_t             last_q, last_d;
  requester_t             owner_q, owner_d;
  logic                   write_q, write_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
  logic [ARB_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [LINE_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic                   avail_q, avail_d;
  logic                   req_valid_q, req_valid_d;
  logic                   i_rv_q, i_rv_d, i_re_q, i_re_d;
  logic                   d_rv_q, d_rv_d, d_re_q, d_re_d;
  logic                   bus_error_q, bus_error_d;

  requester_t winner;
  logic       any_req;

  mem_bus_rr_pick u_pick (
    .req        ({d_read | d_write, i_read}),
    .last_grant (last_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    resp_data_d = resp_data_q;
    bus_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ISSUE;
          owner_d = winner;
          last_d  = winner;
          if (winner == DCACHE) begin
            write_d = d_write;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            write_d = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // a response in the final watchdog cycle still wins over the timeout
        if (mem_resp_valid) begin
          if (!write_q) resp_data_d = mem_resp_data;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d       = 1'b1;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // outputs are registered from the next state so they line up with it
    avail_d     = (state_d == IDLE);
    req_valid_d = (state_d == ISSUE);
    i_rv_d      = (state_d == DONE) && (owner_d == ICACHE);
    d_rv_d      = (state_d == DONE) && (owner_d == DCACHE);
    i_re_d      = i_rv_d && err_d;
    d_re_d      = d_rv_d && err_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= DCACHE;
      owner_q     <= ICACHE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      resp_data_q <= '0;
      avail_q     <= 1'b1;
      req_valid_q <= 1'b0;
      i_rv_q      <= 1'b0;
      i_re_q      <= 1'b0;
      d_rv_q      <= 1'b0;
      d_re_q      <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      resp_data_q <= resp_data_d;
      avail_q     <= avail_d;
      req_valid_q <= req_valid_d;
      i_rv_q      <= i_rv_d;
      i_re_q      <= i_re_d;
      d_rv_q      <= d_rv_d;
      d_re_q      <= d_re_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign i_available   = avail_q;
  assign d_available   = avail_q;
  assign i_resp_valid  = i_rv_q;
  assign i_resp_error  = i_re_q;
  assign d_resp_valid  = d_rv_q;
  assign d_resp_error  = d_re_q;
  assign resp_data     = resp_data_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_write = write_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Transaction-level self-checking bench for mem_bus_arbiter; the bench plays both caches and memory.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 20;
  localparam int unsigned LW = 128;
  localparam int unsigned TO = 8;

  logic          clock;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic          i_available, i_resp_valid, i_resp_error;
  logic          d_read, d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic          d_available, d_resp_valid, d_resp_error;
  logic [LW-1:0] resp_data;
  logic          mem_req_valid, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_req_ready, mem_resp_valid;
  logic [LW-1:0] mem_resp_data;
  logic          bus_error;

  mem_bus_arbiter #(
    .ADDR_WIDTH     (AW),
    .LINE_WIDTH     (LW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .i_read         (i_read),
    .i_addr         (i_addr),
    .i_available    (i_available),
    .i_resp_valid   (i_resp_valid),
    .i_resp_error   (i_resp_error),
    .d_read         (d_read),
    .d_write        (d_write),
    .d_addr         (d_addr),
    .d_wdata        (d_wdata),
    .d_available    (d_available),
    .d_resp_valid   (d_resp_valid),
    .d_resp_error   (d_resp_error),
    .resp_data      (resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .bus_error      (bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // reference model: who was granted last (1 = dcache) and the last line read successfully
  bit            m_last_d;
  logic [LW-1:0] m_rdata;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    i_read         = 1'b0;
    i_addr         = '0;
    d_read         = 1'b0;
    d_write        = 1'b0;
    d_addr         = '0;
    d_wdata        = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    #1;
    check_eq("rst_avail", {i_available, d_available}, 2'b11);
    check_eq("rst_req", {mem_req_valid, mem_req_write}, 2'b00);
    check_eq("rst_addr", mem_req_addr, '0);
    check_eq("rst_wdata", mem_req_wdata, '0);
    check_eq("rst_resp", {i_resp_valid, i_resp_error, d_resp_valid, d_resp_error, bus_error}, 5'b0);
    check_eq("rst_rdata", resp_data, '0);
    @(negedge clock);
    reset    = 1'b1;
    m_last_d = 1'b1;
    m_rdata  = '0;
  endtask

  // One full transaction starting at a negedge with the DUT idle; at least one requester active.
  // rdly: cycles memory withholds ready; pdly: WAIT cycles before the response (>= TO means never).
  task automatic run_txn(input bit ir, input logic [AW-1:0] ia,
                         input bit dr, input bit dw, input logic [AW-1:0] da, input logic [LW-1:0] wd,
                         input int unsigned rdly, input int unsigned pdly,
                         input logic [LW-1:0] rd, input bit stray);
    bit            win_d, exp_w, to;
    logic [AW-1:0] exp_a;
    int unsigned   last;

    i_read  = ir;
    i_addr  = ia;
    d_read  = dr;
    d_write = dw;
    d_addr  = da;
    d_wdata = wd;

    if (ir && (dr || dw)) win_d = !m_last_d;
    else                  win_d = dr || dw;
    m_last_d = win_d;
    exp_w    = win_d && dw;
    exp_a    = win_d ? da : ia;
    to       = (pdly >= TO);
    last     = to ? TO - 1 : pdly;

    mem_req_ready = 1'b0;
    tick();
    check_eq("issue_valid", mem_req_valid, 1'b1);
    check_eq("issue_addr", mem_req_addr, exp_a);
    check_eq("issue_write", mem_req_write, exp_w);
    if (exp_w) check_eq("issue_wdata", mem_req_wdata, wd);
    check_eq("issue_avail", {i_available, d_available}, 2'b00);

    for (int unsigned r = 0; r < rdly; r++) begin
      mem_resp_valid = stray;
      mem_resp_data  = {4{$urandom}};
      tick();
      mem_resp_valid = 1'b0;
      check_eq("hold_valid", mem_req_valid, 1'b1);
      check_eq("hold_addr", mem_req_addr, exp_a);
      check_eq("hold_write", mem_req_write, exp_w);
      if (exp_w) check_eq("hold_wdata", mem_req_wdata, wd);
    end

    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check_eq("wait_novalid", mem_req_valid, 1'b0);

    for (int unsigned j = 0; j <= last; j++) begin
      if (j == pdly && !to) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = rd;
      end else begin
        mem_req_ready = stray;
      end
      tick();
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b0;
      if (j < last)
        check_eq("wait_noresp", {i_resp_valid, d_resp_valid, bus_error, i_available}, 4'b0);
    end

    if (!to && !exp_w) m_rdata = rd;
    check_eq("done_i_valid", i_resp_valid, !win_d);
    check_eq("done_d_valid", d_resp_valid, win_d);
    check_eq("done_i_error", i_resp_error, !win_d && to);
    check_eq("done_d_error", d_resp_error, win_d && to);
    check_eq("done_bus_error", bus_error, to);
    check_eq("done_rdata", resp_data, m_rdata);
    check_eq("done_avail", {i_available, d_available}, 2'b00);

    tick();
    check_eq("idle_avail", {i_available, d_available}, 2'b11);
    check_eq("idle_quiet", {i_resp_valid, d_resp_valid, bus_error, mem_req_valid}, 4'b0);
  endtask

  initial begin
    logic [LW-1:0] a5, w1234;
    a5    = {16{8'hA5}};
    w1234 = {8{16'h1234}};
    reset = 1'b0;
    m_last_d = 1'b1;
    m_rdata  = '0;
    clear_inputs();

    do_reset();

    // idle with nothing requested, plus stray memory handshakes, must not start anything
    mem_resp_valid = 1'b1;
    mem_req_ready  = 1'b1;
    tick();
    tick();
    check_eq("idle_stray", {mem_req_valid, i_resp_valid, d_resp_valid, i_available}, 4'b0001);
    clear_inputs();

    // first tie after reset goes to the icache, then the dcache
    run_txn(1, 20'h00100, 1, 0, 20'h00200, '0, 0, 2, {4{32'h11112222}}, 0);
    run_txn(1, 20'h00100, 1, 0, 20'h00200, '0, 0, 2, {4{32'h33334444}}, 0);
    clear_inputs();

    // icache-only read, resp after 3 wait cycles
    run_txn(1, 20'h00040, 0, 0, '0, '0, 0, 3, a5, 0);
    clear_inputs();

    // dcache write under 5 cycles of backpressure: resp_data must not change
    run_txn(0, '0, 0, 1, 20'h00300, w1234, 5, 1, {4{32'hDEADBEEF}}, 0);
    // read+write together is a write
    run_txn(0, '0, 1, 1, 20'h00310, w1234, 1, 0, {4{32'hCAFEF00D}}, 0);
    // response in the last watchdog cycle beats the timeout
    run_txn(0, '0, 1, 0, 20'h00320, '0, 0, TO - 1, {4{32'h0BADF00D}}, 0);
    // memory never answers
    run_txn(0, '0, 1, 0, 20'h00330, '0, 0, TO, '0, 0);
    clear_inputs();

    // reset during WAIT drops the transaction; a later stray response is ignored
    d_read = 1'b1;
    d_addr = 20'h00440;
    tick();
    mem_req_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
    reset = 1'b0;
    #1;
    check_eq("midrst_avail", {i_available, d_available}, 2'b11);
    check_eq("midrst_quiet", {mem_req_valid, i_resp_valid, d_resp_valid, bus_error}, 4'b0);
    @(negedge clock);
    reset    = 1'b1;
    m_last_d = 1'b1;
    m_rdata  = '0;
    tick();
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = a5;
    tick();
    mem_resp_valid = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      check_eq("postrst_quiet", {i_resp_valid, d_resp_valid, mem_req_valid, bus_error}, 4'b0);
      check_eq("postrst_avail", {i_available, d_available}, 2'b11);
      check_eq("postrst_rdata", resp_data, '0);
      tick();
    end

    // continuous contention alternates I, D, I, D, I, D
    for (int unsigned n = 0; n < 6; n++)
      run_txn(1, 20'h01000 + AW'(n), 1, 0, 20'h02000 + AW'(n), '0, n % 2, 1, {4{$urandom}}, 0);
    clear_inputs();

    // randomized traffic
    for (int unsigned n = 0; n < 40; n++) begin
      bit ir, dr, dw;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      if (!ir && !dr && !dw) ir = 1'b1;
      run_txn(ir, AW'($urandom), dr, dw, AW'($urandom), {4{$urandom}},
              $urandom_range(0, 3), $urandom_range(0, 10), {4{$urandom}}, 1'($urandom_range(0, 1)));
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single external memory bus between the instruction cache (fetch stage) and the data cache (memory stage).
- Owns the per-requester bus-available signals and runs one transaction at a time: grant, issue, wait, respond.
- Routes each memory response back to the owning cache.
- A watchdog terminates hung transactions with an error response.

Parameters:
- ADDR_WIDTH, 20, physical line address width (equals PHYSICAL_ADDR_WIDTH).
- LINE_WIDTH, 128, cache line data width in bits.
- TIMEOUT_CYCLES, 255, cycles to wait for mem_resp_valid before aborting; legal range 1..65535.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i_read  in  1  icache read request.
- i_addr  in  ADDR_WIDTH  icache request address.
- i_available  out  1  icache may present a request.
- i_resp_valid  out  1  one-cycle response pulse to icache.
- i_resp_error  out  1  qualifies i_resp_valid; the transaction timed out.
- d_read  in  1  dcache read (line fill).
- d_write  in  1  dcache write (line eviction).
- d_addr  in  ADDR_WIDTH  dcache request address.
- d_wdata  in  LINE_WIDTH  dcache write line.
- d_available  out  1  dcache may present a request.
- d_resp_valid  out  1  one-cycle response pulse to dcache.
- d_resp_error  out  1  qualifies d_resp_valid; the transaction timed out.
- resp_data  out  LINE_WIDTH  registered read line, shared by both requesters.
- mem_req_valid  out  1  request to memory.
- mem_req_write  out  1  1 = write, 0 = read.
- mem_req_addr  out  ADDR_WIDTH  latched address.
- mem_req_wdata  out  LINE_WIDTH  latched write line.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_resp_valid  in  1  memory completion (read data or write ack).
- mem_resp_data  in  LINE_WIDTH  read line.
- bus_error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State is IDLE; last_grant = DCACHE; timeout counter = 0; latched request registers = 0.
  - All outputs are 0, except i_available = d_available = 1 (they follow IDLE).
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: i_available = d_available = 1. A requester is active when i_read, or d_read|d_write, is high.
    - If any requester is active: pick a winner, latch owner/write/addr/wdata and go to ISSUE.
    - If both are active: grant the requester that is not last_grant, then update last_grant to the winner. The first tie after reset goes to the icache.
    - If d_read and d_write are both high: treat it as a write.
    - Request inputs are only sampled in IDLE; requesters may deassert them at any time before the grant.
  - ISSUE: mem_req_valid = 1 with the latched fields held stable. When mem_req_ready = 1, go to WAIT and clear the counter.
  - WAIT:
    - The counter increments every cycle.
    - On mem_resp_valid: register resp_data (reads only; writes leave resp_data unchanged), set error = 0, go to DONE.
    - If the counter reaches TIMEOUT_CYCLES-1 without mem_resp_valid: set error = 1, pulse bus_error, go to DONE.
    - Resp_valid takes precedence over timeout in the same cycle.
  - DONE: for one cycle, assert the owner's x_resp_valid and x_resp_error = error; then return to IDLE.
- Available outputs: both are 0 in ISSUE, WAIT and DONE.
- Minimum latency: request seen in IDLE at cycle 0 → ISSUE at cycle 1 (ready the same cycle) → WAIT at cycle 2. Resp at cycle k gives DONE and the resp pulse at cycle k+1, and IDLE at k+2.
- Stray signals: mem_resp_valid in IDLE, ISSUE or DONE is ignored. mem_req_ready outside ISSUE is ignored.
- No timeout in ISSUE: memory backpressure may be unbounded.
- Reset mid-transaction: the transaction is dropped, no response pulse is generated, and a later stray mem_resp_valid is ignored.
- Counter: 16 bits, saturating. A wrap can never occur because the timeout fires first.
- resp_data is held until the next read completes.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - requester_t enum {ICACHE, DCACHE}.
  - ARB_TIMEOUT_DEFAULT constant.
- One sub-module, mem_bus_rr_pick: combinational 2-way round-robin picker. Inputs req[1:0] and last_grant; outputs winner and any_req.

Test Plan:
- Icache-only read, addr 0x00040, memory ready at once, resp after 3 cycles with data 0xA5..A5 → i_resp_valid pulses once at resp+1 with i_resp_error = 0 and resp_data = 0xA5..A5; d_resp_valid stays 0.
- Simultaneous i_read (0x00100) and d_read (0x00200) right after reset → icache is served first; at the next IDLE the dcache is served; mem_req_addr sequence is 0x00100 then 0x00200.
- Dcache write, addr 0x00300, wdata 0x1234.., memory ready held low for 5 cycles → mem_req_valid is held with stable fields for 5 cycles; the write ack produces d_resp_valid; resp_data is unchanged.
- TIMEOUT_CYCLES = 8, memory never responds → bus_error and d_resp_error pulse at WAIT cycle 8; both available signals return to 1 one cycle later.
- reset asserted during WAIT, then mem_resp_valid arrives 2 cycles after release → no resp pulse; state is IDLE; both available = 1.
- Continuous i_read and d_read for 6 transactions → grants alternate I, D, I, D, I, D, with no starvation.
